// File: rtl/pb_byte_tx.sv
// Button-driven UART transmitter: each accepted send_next sends byte_cnt as one 8N1 frame (8E1 with `PB_TX_PARITY_EN), then byte_cnt increments.
// Latency: TX drops to the start bit one clock after send_next is sampled. One request is queued while busy, any further one is dropped and flagged on drop.
module pb_byte_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_next,
    output logic       TX,
    output logic       tx_busy,
    output logic [7:0] byte_cnt,
    output logic       drop
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PB_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          drop_q, drop_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          baud_wrap;
`ifdef PB_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        drop_d    = 1'b0;
`ifdef PB_TX_PARITY_EN
        par_d     = par_q;
`endif
        baud_wrap = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (send_next || pending_q) begin
                    state_d   = START;
                    shift_d   = cnt_q;
                    baud_d    = '0;
                    bit_d     = 3'd0;
                    // A fresh request arriving while the queued one launches stays queued.
                    pending_d = send_next && pending_q;
`ifdef PB_TX_PARITY_EN
                    par_d     = ^cnt_q;
`endif
                end
            end
            START: begin
                if (baud_wrap) state_d = DATA;
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef PB_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef PB_TX_PARITY_EN
            PARITY: begin
                if (baud_wrap) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests while a frame is on the line, including its last stop clock.
        if (send_next && (state_q != IDLE)) begin
            if (pending_q) drop_d = 1'b1;
            else           pending_d = 1'b1;
        end

        // Outputs are registered, so derive them from the next state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef PB_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            cnt_q     <= 8'h00;
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef PB_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign TX       = tx_q;
    assign tx_busy  = busy_q;
    assign byte_cnt = cnt_q;
    assign drop     = drop_q;

endmodule
